baud_tick_generator: RTL and testbench
======================================

// Module: baud_tick_generator
// PURPOSE
//  Programmable fractional-N tick generator for the UART link. Emits single-cycle
//  sample_tick enables at OVERSAMPLE x baud for the receiver and baud_tick enables
//  at 1 x baud for the transmitter. Divisor is runtime-loadable via a valid/ready port.
//  Phase can be realigned by the receiver on start-bit detect. Ticks are enables, never clocks.
// PARAMETERS
//  DIV_W          16    width of integer divisor / down-counter
//  FRAC_W         4     width of fractional divisor / phase accumulator
//  OVERSAMPLE     16    sample ticks per baud tick, power of two, >=2
//  RST_DIV_INT    651   integer divisor after reset (100 MHz / 153600 = 651.04)
//  RST_DIV_FRAC   1     fractional divisor after reset, in units of 2^-FRAC_W
// PORTS
//  clk          in   1                       system clock
//  reset        in   1                       async, active-low
//  en           in   1                       count enable; low = freeze all state
//  sync_clear   in   1                       realign: restart period, phase := 0
//  cfg_valid    in   1                       new divisor offered
//  cfg_ready    out  1                       divisor shadow free
//  cfg_div_int  in   DIV_W                   integer divisor, legal >= 2
//  cfg_div_frac in   FRAC_W                  fractional divisor
//  cfg_err      out  1                       1-cycle pulse: illegal divisor rejected
//  sample_tick  out  1                       1-cycle pulse, OVERSAMPLE x baud
//  baud_tick    out  1                       1-cycle pulse, coincident with every OVERSAMPLE-th sample_tick
//  phase        out  $clog2(OVERSAMPLE)      sample index within current bit
// BEHAVIOUR
//  Reset (async, immediate, also mid-operation): div := RST_*; cnt := RST_DIV_INT-1;
//   acc := 0; phase := 0; sample_tick = baud_tick = cfg_err = 0; cfg_ready = 1; shadow empty.
//  Counting (en=1): cnt decrements each clk. At cnt==0: sample_tick=1 on next cycle (registered);
//   {carry,acc} := acc + div_frac; cnt := div_int - 1 + carry. Sample period = div_int or div_int+1 clks;
//   mean = div_int + div_frac/2^FRAC_W. First tick: div_int clks after en rises out of reset.
//  Phase: increments on each tick, wraps OVERSAMPLE-1 -> 0; baud_tick=1 in the same cycle as the
//   sample_tick whose increment wraps phase to 0. phase shows post-increment value with the tick.
//  en=0: cnt, acc, phase, shadow all hold; no ticks; tick resumes exactly where frozen.
//  Config handshake: accept when cfg_valid & cfg_ready. If cfg_div_int < 2: not stored, cfg_err=1
//   for one cycle next clk, cfg_ready stays 1. Else stored in shadow, cfg_ready=0 next clk.
//   Shadow applied at next reload point (cnt==0 with en=1), or next clk if en=0, or on sync_clear:
//   div := shadow, acc := 0, reload uses NEW div_int; cfg_ready returns 1 the cycle after apply.
//   In-flight period always completes with the OLD divisor.
//  sync_clear (sync, priority over all but reset): cnt := div_int-1 (shadow if pending), acc := 0,
//   phase := 0; no tick emitted that cycle even if cnt==0. Works with en=0.
//  cfg_valid while cfg_ready=0: ignored (no acceptance, no error).
//  Arithmetic: cnt/acc unsigned, acc wraps mod 2^FRAC_W; no output can glitch (all registered).
// STRUCTURE
//  Shared package uart_pkg: OVERSAMPLE default, RST_DIV_INT/RST_DIV_FRAC for 100 MHz/9600 baud,
//   DIV_W/FRAC_W defaults, PHASE_W = $clog2(OVERSAMPLE).
//  Top: divisor shadow + handshake, down-counter, fractional accumulator.
//  One sub-module: baud_phase_counter (sample_tick, sync_clear in; phase, baud_tick out).
// TESTING
//  1 Reset: reset low mid-period with cnt=37, phase=9 -> same instant all outputs 0, phase=0, cfg_ready=1.
//  2 Load div 4.0, en=1 -> sample_tick every 4 clks, baud_tick every 64 clks with phase=0.
//  3 Reset divisor 651.1 (FRAC_W=4) -> 16 consecutive periods: fifteen 651, one 652, total 10417 clks.
//  4 Running at 4, load 10 at cnt=2 -> next tick 3 clks later, following 10 apart; cfg_ready low until then.
//  5 cfg_div_int=1 -> cfg_err pulse 1 clk, divisor unchanged, cfg_ready stays 1.
//  6 en low 7 clks mid-period -> tick delayed by exactly 7; sync_clear at cnt==0 -> no tick, phase=0,
//    next tick div_int clks later.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART link constants: default widths, oversampling ratio and the
// reset divisor for a 100 MHz system clock running the link at 9600 baud.
package uart_pkg;

  localparam int DEFAULT_DIV_W      = 16;
  localparam int DEFAULT_FRAC_W     = 4;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int PHASE_W            = $clog2(DEFAULT_OVERSAMPLE);

  // 100 MHz / (9600 * 16) = 651.04, rounded to 651 + 1/16
  localparam int DEFAULT_RST_DIV_INT  = 651;
  localparam int DEFAULT_RST_DIV_FRAC = 1;

endpackage

// File: rtl/baud_phase_counter.sv
// Tracks the sample index within the current bit and flags the sample tick
// that closes a bit period (phase wrapping back to zero).
module baud_phase_counter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_tick,
  input  logic                          sync_clear,
  output logic [$clog2(OVERSAMPLE)-1:0] phase,
  output logic                          baud_tick
);

  localparam int PH_W = $clog2(OVERSAMPLE);

  logic [PH_W-1:0] phase_q, phase_d;
  logic            baud_q, baud_d;

  // OVERSAMPLE is a power of two, so the natural wrap of phase_q + 1 is the modulo
  always_comb begin
    phase_d = phase_q;
    baud_d  = 1'b0;
    if (sync_clear) begin
      phase_d = '0;
    end else if (sample_tick) begin
      phase_d = phase_q + PH_W'(1);
      baud_d  = (phase_q == PH_W'(OVERSAMPLE - 1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      baud_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      baud_q  <= baud_d;
    end
  end

  assign phase     = phase_q;
  assign baud_tick = baud_q;

endmodule

// File: rtl/baud_tick_generator.sv
// Fractional-N baud tick generator: runtime-loadable divisor shadow, period
// down-counter and fractional phase accumulator; all outputs are registered enables.
module baud_tick_generator
  import uart_pkg::*;
#(
  parameter int DIV_W        = DEFAULT_DIV_W,
  parameter int FRAC_W       = DEFAULT_FRAC_W,
  parameter int OVERSAMPLE   = DEFAULT_OVERSAMPLE,
  parameter int RST_DIV_INT  = DEFAULT_RST_DIV_INT,
  parameter int RST_DIV_FRAC = DEFAULT_RST_DIV_FRAC
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          sync_clear,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [DIV_W-1:0]              cfg_div_int,
  input  logic [FRAC_W-1:0]             cfg_div_frac,
  output logic                          cfg_err,
  output logic                          sample_tick,
  output logic                          baud_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] phase
);

  localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(RST_DIV_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RST_DIV_FRAC);

  logic [DIV_W-1:0]  div_int_q, div_int_d;
  logic [FRAC_W-1:0] div_frac_q, div_frac_d;
  logic [DIV_W-1:0]  shd_int_q, shd_int_d;
  logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
  logic              shd_valid_q, shd_valid_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              tick_q, tick_d;
  logic              err_q, err_d;

  logic [FRAC_W:0]   acc_sum;
  logic              accept;
  logic              reload_pt;
  logic              apply_shd;

  // A pending divisor takes effect only at a period boundary, while frozen, or on
  // realign, so an in-flight period always finishes on the old divisor.
  always_comb begin
    acc_sum     = {1'b0, acc_q} + {1'b0, div_frac_q};
    accept      = cfg_valid & ~shd_valid_q;
    reload_pt   = en & (cnt_q == '0);
    apply_shd   = shd_valid_q & (sync_clear | ~en | reload_pt);
    div_int_d   = apply_shd ? shd_int_q : div_int_q;
    div_frac_d  = apply_shd ? shd_frac_q : div_frac_q;
    shd_int_d   = shd_int_q;
    shd_frac_d  = shd_frac_q;
    shd_valid_d = shd_valid_q & ~apply_shd;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    tick_d      = 1'b0;
    err_d       = accept & (cfg_div_int < DIV_W'(2));

    if (sync_clear) begin
      cnt_d = div_int_d - DIV_W'(1);
      acc_d = '0;
    end else if (reload_pt) begin
      tick_d = 1'b1;
      if (apply_shd) begin
        cnt_d = div_int_d - DIV_W'(1);
        acc_d = '0;
      end else begin
        cnt_d = div_int_q - DIV_W'(1) + {{(DIV_W-1){1'b0}}, acc_sum[FRAC_W]};
        acc_d = acc_sum[FRAC_W-1:0];
      end
    end else if (en) begin
      cnt_d = cnt_q - DIV_W'(1);
    end else if (apply_shd) begin
      acc_d = '0;
    end

    if (accept && !err_d) begin
      shd_int_d   = cfg_div_int;
      shd_frac_d  = cfg_div_frac;
      shd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_int_q   <= RST_INT;
      div_frac_q  <= RST_FRAC;
      shd_int_q   <= '0;
      shd_frac_q  <= '0;
      shd_valid_q <= 1'b0;
      cnt_q       <= RST_INT - DIV_W'(1);
      acc_q       <= '0;
      tick_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      div_int_q   <= div_int_d;
      div_frac_q  <= div_frac_d;
      shd_int_q   <= shd_int_d;
      shd_frac_q  <= shd_frac_d;
      shd_valid_q <= shd_valid_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      tick_q      <= tick_d;
      err_q       <= err_d;
    end
  end

  baud_phase_counter #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_phase (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (tick_d),
    .sync_clear  (sync_clear),
    .phase       (phase),
    .baud_tick   (baud_tick)
  );

  assign cfg_ready   = ~shd_valid_q;
  assign cfg_err     = err_q;
  assign sample_tick = tick_q;

endmodule

// File: tb/tb_baud_tick_generator.sv
// Self-checking bench for baud_tick_generator: directed scenarios plus a random
// soak, every cycle compared against a period-level behavioural model.
module tb_baud_tick_generator;

  localparam int FRAC_W = 4;
  localparam int OS     = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        sync_clear = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_div_int = '0;
  logic [3:0]  cfg_div_frac = '0;
  logic        cfg_ready, cfg_err, sample_tick, baud_tick;
  logic [3:0]  phase;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit tick_seen, baud_seen;

  // Model: period length, enabled clocks elapsed in it, reloads since the
  // fraction was cleared, and ticks since the phase was cleared.
  int m_div_int, m_div_frac, m_pend_int, m_pend_frac;
  bit m_pend;
  int m_plen, m_elapsed, m_n, m_ticks;
  bit m_exp_tick, m_exp_baud, m_exp_err;

  always #5 clk = ~clk;

  baud_tick_generator dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .sync_clear   (sync_clear),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_err      (cfg_err),
    .sample_tick  (sample_tick),
    .baud_tick    (baud_tick),
    .phase        (phase)
  );

  task automatic check_output(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Number of extra clocks owed after the n-th reload: floor(n*f/2^F) - floor((n-1)*f/2^F)
  function automatic int carry_of(input int n, input int f);
    return ((n * f) >> FRAC_W) - (((n - 1) * f) >> FRAC_W);
  endfunction

  task automatic model_reset();
    m_div_int  = 651;
    m_div_frac = 1;
    m_pend     = 1'b0;
    m_plen     = 651;
    m_elapsed  = 0;
    m_n        = 0;
    m_ticks    = 0;
  endtask

  task automatic model_apply();
    m_div_int  = m_pend_int;
    m_div_frac = m_pend_frac;
    m_pend     = 1'b0;
    m_n        = 0;
  endtask

  task automatic model_step(input bit e, input bit s, input bit v, input int di, input int df);
    bit accept;
    accept     = v && !m_pend;
    m_exp_tick = 1'b0;
    m_exp_baud = 1'b0;
    m_exp_err  = 1'b0;
    if (s) begin
      if (m_pend) model_apply();
      m_plen    = m_div_int;
      m_elapsed = 0;
      m_n       = 0;
      m_ticks   = 0;
    end else if (e) begin
      m_elapsed++;
      if (m_elapsed == m_plen) begin
        m_exp_tick = 1'b1;
        m_ticks++;
        m_exp_baud = (m_ticks % OS) == 0;
        if (m_pend) begin
          model_apply();
          m_plen = m_div_int;
        end else begin
          m_n++;
          m_plen = m_div_int + carry_of(m_n, m_div_frac);
        end
        m_elapsed = 0;
      end
    end else if (m_pend) begin
      model_apply();
    end
    if (accept) begin
      if (di < 2) m_exp_err = 1'b1;
      else begin
        m_pend      = 1'b1;
        m_pend_int  = di;
        m_pend_frac = df;
      end
    end
  endtask

  function automatic int model_cnt();
    return m_plen - 1 - m_elapsed;
  endfunction

  task automatic apply_stimulus(input bit e, input bit s, input bit v, input int di, input int df);
    @(negedge clk);
    en           = e;
    sync_clear   = s;
    cfg_valid    = v;
    cfg_div_int  = 16'(di);
    cfg_div_frac = 4'(df);
    @(posedge clk);
    cyc++;
    model_step(e, s, v, di, df);
    #1;
    tick_seen = sample_tick;
    baud_seen = baud_tick;
    check_output("sample_tick", int'(sample_tick), int'(m_exp_tick));
    check_output("baud_tick", int'(baud_tick), int'(m_exp_baud));
    check_output("phase", int'(phase), m_ticks % OS);
    check_output("cfg_ready", int'(cfg_ready), int'(!m_pend));
    check_output("cfg_err", int'(cfg_err), int'(m_exp_err));
  endtask

  task automatic wait_tick(input int limit, output int when);
    when = -1;
    for (int i = 0; i < limit; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0);
      if (tick_seen) begin
        when = cyc;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_sample_tick"}, int'(sample_tick), 0);
    check_output({tag, "_baud_tick"}, int'(baud_tick), 0);
    check_output({tag, "_cfg_err"}, int'(cfg_err), 0);
    check_output({tag, "_phase"}, int'(phase), 0);
    check_output({tag, "_cfg_ready"}, int'(cfg_ready), 1);
  endtask

  initial begin
    int t1, prev, n652, cnt_ticks, bad, b1, b2, t_start, ta, tb, last;

    #1 reset = 1'b0;
    #1 check_reset_outputs("por");
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] reset divisor 651 + 1/16 over sixteen periods");
    t1 = -1; prev = -1; n652 = 0; cnt_ticks = 0;
    for (int i = 0; i < 12000 && cnt_ticks < 17; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0);
      if (tick_seen) begin
        cnt_ticks++;
        if (cnt_ticks == 1) t1 = cyc;
        else if (cyc - prev == 652) n652++;
        prev = cyc;
      end
    end
    check_output("first_tick_latency", t1, 651);
    check_output("span_16_periods", prev - t1, 10417);
    check_output("periods_of_652", n652, 1);

    $display("[TB] illegal divisors rejected");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1, 3);
    check_output("err_pulse_div1", int'(cfg_err), 1);
    apply_stimulus(1'b1, 1'b0, 1'b1, 0, 0);
    check_output("err_pulse_div0", int'(cfg_err), 1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0);

    $display("[TB] load divisor 4.0");
    apply_stimulus(1'b1, 1'b0, 1'b1, 4, 0);
    wait_tick(700, ta);
    check_output("load4_applied", int'(ta > 0), 1);
    prev = ta; bad = 0; b1 = -1; b2 = -1;
    for (int i = 0; i < 140; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0);
      if (tick_seen) begin
        if (cyc - prev != 4) bad++;
        prev = cyc;
      end
      if (baud_seen) begin
        if (b1 < 0) b1 = cyc;
        else if (b2 < 0) b2 = cyc;
      end
    end
    check_output("tick_interval_4_bad", bad, 0);
    check_output("baud_interval", b2 - b1, 64);

    $display("[TB] load 10 with count at 2");
    for (int i = 0; i < 10 && model_cnt() != 2; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0);
    t_start = cyc;
    apply_stimulus(1'b1, 1'b0, 1'b1, 10, 0);
    wait_tick(20, ta);
    check_output("reload_tick_delay", ta - t_start, 3);
    wait_tick(20, tb);
    check_output("new_period_10", tb - ta, 10);

    $display("[TB] freeze for 7 clocks mid-period");
    last = tb;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 7; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0);
    wait_tick(30, ta);
    check_output("frozen_period", ta - last, 17);

    $display("[TB] sync_clear on terminal count");
    for (int i = 0; i < 20 && model_cnt() != 0; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 0, 0);
    check_output("sync_no_tick", int'(sample_tick), 0);
    check_output("sync_phase", int'(phase), 0);
    t_start = cyc;
    wait_tick(30, ta);
    check_output("sync_next_tick", ta - t_start, 10);

    $display("[TB] asynchronous reset mid-period");
    apply_stimulus(1'b1, 1'b0, 1'b1, 50, 0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 2000 && !((m_ticks % OS) == 9 && model_cnt() == 37); i++)
      apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0);
    check_output("pre_reset_phase", int'(phase), 9);
    #2;
    en = 1'b0; sync_clear = 1'b0; cfg_valid = 1'b0;
    reset = 1'b0;
    #1 check_reset_outputs("async");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] random soak");
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 9), $urandom_range(0, 15));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
